// File: rtl/opfetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// opfetch_stage_pkg
// Shared definitions for the operand-fetch stage: architectural sizes,
// instruction field layout, ALU opcode map and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package opfetch_stage_pkg;

    localparam int NREGS = 16;
    localparam int XLEN  = 32;
    localparam int REG_W = $clog2(NREGS);
    localparam int OP_W  = 5;
    localparam int IMM_W = 16;

    // Instruction field offsets
    localparam int OP_LSB  = 27;
    localparam int RI_BIT  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS1_LSB = 18;
    localparam int RS2_LSB = 14;
    localparam int IMM_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        ALUOP_ADD  = 5'h00,
        ALUOP_SUB  = 5'h01,
        ALUOP_AND  = 5'h02,
        ALUOP_OR   = 5'h03,
        ALUOP_XOR  = 5'h04,
        ALUOP_SHL  = 5'h05,
        ALUOP_SHR  = 5'h06,
        ALUOP_SRA  = 5'h07,
        ALUOP_MUL  = 5'h08,
        ALUOP_CMP  = 5'h09,
        ALUOP_MOV  = 5'h0A,
        ALUOP_MOVH = 5'h0B,
        ALUOP_NOT  = 5'h0C,
        ALUOP_NEG  = 5'h0D
    } aluop_e;

    localparam logic [OP_W-1:0] ALU_OP_MAX = 5'h0D;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic             ri;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } decoded_t;

    function automatic decoded_t decode_instr(input logic [XLEN-1:0] instr);
        decoded_t d;
        d.op  = instr[OP_LSB  +: OP_W];
        d.ri  = instr[RI_BIT];
        d.rd  = instr[RD_LSB  +: REG_W];
        d.rs1 = instr[RS1_LSB +: REG_W];
        d.rs2 = instr[RS2_LSB +: REG_W];
        d.imm = instr[IMM_LSB +: IMM_W];
        return d;
    endfunction

    // One-hot mask selecting a single scoreboard bit.
    function automatic logic [NREGS-1:0] reg_mask(input logic [REG_W-1:0] r);
        logic [NREGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/opfetch_stage_if.sv
// -----------------------------------------------------------------------------
// opfetch_stage_if
// Bundles the three channels of the operand-fetch stage:
//   upstream  : in_valid, in_ready, instr
//   downstream: out_valid, out_ready, val1, val2, aluop, is_alu_op, out_rd
//   writeback : wb_en, wb_rd, wb_data
// slave  = the stage itself; master = the surrounding pipeline / bench.
// -----------------------------------------------------------------------------
interface opfetch_stage_if;
    import opfetch_stage_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       instr;

    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       val1;
    logic [XLEN-1:0]       val2;
    logic [OP_W-1:0]       aluop;
    logic                  is_alu_op;
    logic [REG_W-1:0]      out_rd;

    logic                  wb_en;
    logic [REG_W-1:0]      wb_rd;
    logic [XLEN-1:0]       wb_data;

    modport slave (
        input  in_valid, instr, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, val1, val2, aluop, is_alu_op, out_rd
    );

    modport master (
        output in_valid, instr, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, val1, val2, aluop, is_alu_op, out_rd
    );

endinterface

// File: rtl/opfetch_stage_regfile.sv
// -----------------------------------------------------------------------------
// opfetch_stage_regfile
// DEPTH x DATA_W register file, entry 0 hard-wired to zero.
//   clk, rst          : clock, synchronous active-high reset (clears all entries)
//   we, waddr, wdata  : synchronous write port (ignored for entry 0 and in reset)
//   raddr1 / rdata1   : asynchronous read port 1, bypasses a same-cycle write
//   raddr2 / rdata2   : asynchronous read port 2, bypasses a same-cycle write
// -----------------------------------------------------------------------------
module opfetch_stage_regfile #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = mem[raddr1];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
    end

    always_comb begin
        rdata2 = mem[raddr2];
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/opfetch_stage.sv
// -----------------------------------------------------------------------------
// opfetch_stage
// Operand fetch / issue stage in front of the ALU. Decodes one instruction per
// cycle, reads the register file (with writeback bypass), stalls on pending
// sources or destination, and registers the operands for the execute stage.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : opfetch_stage_if.slave (upstream, downstream and writeback channels)
// -----------------------------------------------------------------------------
module opfetch_stage
    import opfetch_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    opfetch_stage_if.slave   bus
);

    decoded_t              dec_p0;
    logic [XLEN-1:0]       rs1_data_p0;
    logic [XLEN-1:0]       rs2_data_p0;
    logic [XLEN-1:0]       val1_p0;
    logic [XLEN-1:0]       val2_p0;
    logic                  is_alu_p0;
    logic                  hazard_p0;
    logic                  in_ready_p0;
    logic                  vld_p0;

    logic [NREGS-1:0]      pend;
    logic [NREGS-1:0]      pend_live;
    logic [NREGS-1:0]      clr_mask;
    logic [NREGS-1:0]      set_mask;

    logic                  vld_p1;
    logic [XLEN-1:0]       val1_p1;
    logic [XLEN-1:0]       val2_p1;
    logic [OP_W-1:0]       aluop_p1;
    logic                  is_alu_p1;
    logic [REG_W-1:0]      rd_p1;

    function automatic logic [XLEN-1:0] sext_imm16(input logic [IMM_W-1:0] imm);
        logic signed [IMM_W-1:0] imm_s;
        logic signed [XLEN-1:0]  imm_x;
        imm_s = imm;
        imm_x = imm_s;
        return imm_x;
    endfunction

    // ---- p0: decode, register read, hazard check ----
    assign dec_p0 = decode_instr(bus.instr);

    opfetch_stage_regfile #(
        .DATA_W (XLEN),
        .DEPTH  (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_en),
        .waddr  (bus.wb_rd),
        .wdata  (bus.wb_data),
        .raddr1 (dec_p0.rs1),
        .rdata1 (rs1_data_p0),
        .raddr2 (dec_p0.rs2),
        .rdata2 (rs2_data_p0)
    );

    assign is_alu_p0 = (dec_p0.op <= ALU_OP_MAX);
    assign val1_p0   = rs1_data_p0;

    always_comb begin
        val2_p0 = rs2_data_p0;
        if (dec_p0.ri) begin
            if (dec_p0.op == ALUOP_MOVH) begin
                val2_p0 = {dec_p0.imm, {(XLEN-IMM_W){1'b0}}};
            end else begin
                val2_p0 = sext_imm16(dec_p0.imm);
            end
        end
    end

    // A writeback landing this cycle resolves its register: the read port
    // bypasses it, so the bit is treated as already clear for hazard purposes.
    assign clr_mask  = bus.wb_en ? reg_mask(bus.wb_rd) : '0;
    assign pend_live = pend & ~clr_mask;

    // in_valid is deliberately kept out of this term so in_ready never
    // depends combinationally on in_valid.
    assign hazard_p0 = pend_live[dec_p0.rs1]
                     | (!dec_p0.ri && pend_live[dec_p0.rs2])
                     | pend_live[dec_p0.rd];

    assign in_ready_p0 = !rst && !hazard_p0 && (!vld_p1 || bus.out_ready);
    assign vld_p0      = bus.in_valid && in_ready_p0;

    // Set is applied after clear so a same-cycle set/clear of one bit leaves it set.
    assign set_mask = (vld_p0 && is_alu_p0 && (dec_p0.rd != '0)) ? reg_mask(dec_p0.rd) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_live | set_mask;
        end
    end

    // ---- p1: issue register toward execute ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            val1_p1   <= '0;
            val2_p1   <= '0;
            aluop_p1  <= '0;
            is_alu_p1 <= 1'b0;
            rd_p1     <= '0;
        end else if (vld_p0) begin
            vld_p1    <= 1'b1;
            val1_p1   <= val1_p0;
            val2_p1   <= val2_p0;
            aluop_p1  <= dec_p0.op;
            is_alu_p1 <= is_alu_p0;
            rd_p1     <= dec_p0.rd;
        end else if (bus.out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_p0;
    assign bus.out_valid = vld_p1;
    assign bus.val1      = val1_p1;
    assign bus.val2      = val2_p1;
    assign bus.aluop     = aluop_p1;
    assign bus.is_alu_op = is_alu_p1;
    assign bus.out_rd    = rd_p1;

endmodule

// File: tb/tb_opfetch_stage.sv
// -----------------------------------------------------------------------------
// tb_opfetch_stage
// Directed bench for opfetch_stage: inputs change on the falling edge, outputs
// are checked on the falling edge against hand-computed values.
// -----------------------------------------------------------------------------
module tb_opfetch_stage;
    import opfetch_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    opfetch_stage_if bus ();

    opfetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_rr(input logic [4:0] op, input logic [3:0] rd,
                                           input logic [3:0] rs1, input logic [3:0] rs2);
        return {op, 1'b0, rd, rs1, rs2, 14'h0};
    endfunction

    function automatic logic [31:0] enc_ri(input logic [4:0] op, input logic [3:0] rd,
                                           input logic [3:0] rs1, input logic [15:0] imm);
        return {op, 1'b1, rd, rs1, 2'b00, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                         input logic we, input logic [3:0] wr, input logic [31:0] wd);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.out_ready = ordy;
        bus.wb_en     = we;
        bus.wb_rd     = wr;
        bus.wb_data   = wd;
        #1;
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [4:0] op, input logic alu,
                             input logic [3:0] rd, input logic [15:0] pnd);
        check_eq({tag, ".out_valid"}, {31'h0, bus.out_valid}, {31'h0, vld});
        check_eq({tag, ".val1"},      bus.val1, v1);
        check_eq({tag, ".val2"},      bus.val2, v2);
        check_eq({tag, ".aluop"},     {27'h0, bus.aluop}, {27'h0, op});
        check_eq({tag, ".is_alu_op"}, {31'h0, bus.is_alu_op}, {31'h0, alu});
        check_eq({tag, ".out_rd"},    {28'h0, bus.out_rd}, {28'h0, rd});
        check_eq({tag, ".pend"},      {16'h0, dut.pend}, {16'h0, pnd});
    endtask

    task automatic check_rdy(input string tag, input logic exp);
        check_eq({tag, ".in_ready"}, {31'h0, bus.in_ready}, {31'h0, exp});
    endtask

    initial begin
        // Reset, with a writeback to r5 that must be discarded
        rst = 1'b1;
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd1, 4'd2, 4'd3), 1'b1, 1'b1, 4'd5, 32'h55);
        check_rdy("rst", 1'b0);
        tick;
        tick;
        check_rdy("rst2", 1'b0);
        check_out("rst", 1'b0, 32'h0, 32'h0, 5'h00, 1'b0, 4'd0, 16'h0000);

        // Preload R2=5, R3=7 through writeback
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd2, 32'd5);
        tick;
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd3, 32'd7);
        tick;

        // ADD rr r1 <- r2, r3
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd1, 4'd2, 4'd3), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("add_rr", 1'b1);
        tick;
        check_out("add_rr", 1'b1, 32'd5, 32'd7, ALUOP_ADD, 1'b1, 4'd1, 16'h0002);

        // ADD ri r6 <- r5 + sext(FFFE); r5 stays 0 since its write came during reset
        drive(1'b1, enc_ri(ALUOP_ADD, 4'd6, 4'd5, 16'hFFFE), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("add_ri", 1'b1);
        tick;
        check_out("add_ri", 1'b1, 32'h0, 32'hFFFF_FFFE, ALUOP_ADD, 1'b1, 4'd6, 16'h0042);

        // MOVH ri r7 <- r2, 1234
        drive(1'b1, enc_ri(ALUOP_MOVH, 4'd7, 4'd2, 16'h1234), 1'b1, 1'b0, 4'd0, 32'h0);
        tick;
        check_out("movh", 1'b1, 32'd5, 32'h1234_0000, ALUOP_MOVH, 1'b1, 4'd7, 16'h00C2);

        // Retire r6 and r7; output drains
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd6, 32'h66);
        tick;
        check_eq("drain.out_valid", {31'h0, bus.out_valid}, 32'h0);
        check_eq("drain.pend", {16'h0, dut.pend}, 32'h0082);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd7, 32'h77);
        tick;
        check_eq("drain2.pend", {16'h0, dut.pend}, 32'h0002);

        // RAW: SUB r4 <- r1, r2 stalls until r1 is written back
        drive(1'b1, enc_rr(ALUOP_SUB, 4'd4, 4'd1, 4'd2), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("raw0", 1'b0);
        tick;
        check_eq("raw0.out_valid", {31'h0, bus.out_valid}, 32'h0);
        drive(1'b1, enc_rr(ALUOP_SUB, 4'd4, 4'd1, 4'd2), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("raw1", 1'b0);
        tick;
        drive(1'b1, enc_rr(ALUOP_SUB, 4'd4, 4'd1, 4'd2), 1'b1, 1'b1, 4'd1, 32'd9);
        check_rdy("raw_wb", 1'b1);
        tick;
        check_out("raw", 1'b1, 32'd9, 32'd5, ALUOP_SUB, 1'b1, 4'd4, 16'h0010);

        // Back-pressure: 3 cycles of out_ready=0, outputs frozen
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, enc_rr(ALUOP_ADD, 4'd8, 4'd2, 4'd3), 1'b0, 1'b0, 4'd0, 32'h0);
            check_rdy("bp", 1'b0);
            tick;
            check_out("bp", 1'b1, 32'd9, 32'd5, ALUOP_SUB, 1'b1, 4'd4, 16'h0010);
        end
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd8, 4'd2, 4'd3), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("bp_rel", 1'b1);
        tick;
        check_out("bp_a", 1'b1, 32'd5, 32'd7, ALUOP_ADD, 1'b1, 4'd8, 16'h0110);
        drive(1'b1, enc_ri(ALUOP_ADD, 4'd9, 4'd3, 16'h0003), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("bp_b", 1'b1);
        tick;
        check_out("bp_b", 1'b1, 32'd7, 32'd3, ALUOP_ADD, 1'b1, 4'd9, 16'h0310);

        // r0: writes ignored, reads zero even with a same-cycle r0 writeback
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 32'hDEAD);
        tick;
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd0, 4'd0, 4'd2), 1'b1, 1'b1, 4'd0, 32'hDEAD);
        check_rdy("r0", 1'b1);
        tick;
        check_out("r0", 1'b1, 32'h0, 32'd5, ALUOP_ADD, 1'b1, 4'd0, 16'h0310);

        // Opcode boundary: 0x0E is not an ALU op, 0x0D is
        drive(1'b1, enc_rr(5'h0E, 4'd10, 4'd2, 4'd3), 1'b1, 1'b0, 4'd0, 32'h0);
        tick;
        check_out("nonalu", 1'b1, 32'd5, 32'd7, 5'h0E, 1'b0, 4'd10, 16'h0310);
        drive(1'b1, enc_rr(ALUOP_NEG, 4'd11, 4'd2, 4'd3), 1'b1, 1'b0, 4'd0, 32'h0);
        tick;
        check_out("opmax", 1'b1, 32'd5, 32'd7, ALUOP_NEG, 1'b1, 4'd11, 16'h0B10);

        // WAW on r4, resolved by a same-cycle writeback; set beats clear
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd4, 4'd2, 4'd3), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("waw", 1'b0);
        tick;
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd4, 4'd2, 4'd3), 1'b1, 1'b1, 4'd4, 32'h44);
        check_rdy("waw_wb", 1'b1);
        tick;
        check_out("waw", 1'b1, 32'd5, 32'd7, ALUOP_ADD, 1'b1, 4'd4, 16'h0B10);

        // Reset while holding a stalled output
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd12, 4'd2, 4'd3), 1'b0, 1'b0, 4'd0, 32'h0);
        check_rdy("hold", 1'b0);
        tick;
        check_out("hold", 1'b1, 32'd5, 32'd7, ALUOP_ADD, 1'b1, 4'd4, 16'h0B10);
        rst = 1'b1;
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd12, 4'd2, 4'd3), 1'b0, 1'b1, 4'd2, 32'h99);
        check_rdy("mid_rst", 1'b0);
        tick;
        check_out("mid_rst", 1'b0, 32'h0, 32'h0, 5'h00, 1'b0, 4'd0, 16'h0000);
        rst = 1'b0;
        drive(1'b1, enc_rr(ALUOP_ADD, 4'd12, 4'd2, 4'd3), 1'b1, 1'b0, 4'd0, 32'h0);
        check_rdy("post_rst", 1'b1);
        tick;
        check_out("post_rst", 1'b1, 32'h0, 32'h0, ALUOP_ADD, 1'b1, 4'd12, 16'h1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
